// File: rtl/duty_mon_pkg.sv
// Shared state encoding and limits for the duty-cycle monitor.
// Build option DUTY_MON_SYNC_EN (see duty_edge_det) does not change anything here.
package duty_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_e;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/duty_edge_det.sv
// Edge detector for the monitored waveform: previous-sample register plus rise/fall strobes.
// Define DUTY_MON_SYNC_EN to insert a 2-flop synchronizer ahead of edge detection.
module duty_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sig_src;
    logic sig_d;
    logic sig_q;

`ifdef DUTY_MON_SYNC_EN
    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sig_src = sync2_q;
`else
    assign sig_src = sig_in;
`endif

    always_comb begin
        sig_d = sig_src;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_src & ~sig_q;
    assign fall = ~sig_src & sig_q;

endmodule

// File: rtl/duty_monitor.sv
// Measures high time and period of a divided-clock waveform and flags duty errors / stuck input.
// DUTY_MON_SYNC_EN (in duty_edge_det) adds two cycles of input synchronization latency.
module duty_monitor
    import duty_mon_pkg::*;
#(
    parameter int PERIOD      = 10,
    parameter int HIGH_CYCLES = 6,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W:0]   meas_period,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             stuck,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] HIGH_EXP   = CNT_W'(HIGH_CYCLES);
    localparam logic [CNT_W:0]   PERIOD_EXP = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == ERR_MAX) ? cnt : cnt + 8'd1;
    endfunction

    logic rise;
    logic fall;

    duty_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_d,       state_q;
    logic [CNT_W-1:0] hi_cnt_d,      hi_cnt_q;
    logic [CNT_W-1:0] lo_cnt_d,      lo_cnt_q;
    logic [CNT_W-1:0] hi_lat_d,      hi_lat_q;
    logic [CNT_W-1:0] meas_high_d,   meas_high_q;
    logic [CNT_W:0]   meas_period_d, meas_period_q;
    logic             meas_valid_d,  meas_valid_q;
    logic             duty_ok_d,     duty_ok_q;
    logic             stuck_d,       stuck_q;
    logic [7:0]       err_cnt_d,     err_cnt_q;

    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] lo_inc;
    logic [CNT_W:0]   period_sum;
    logic             period_match;

    always_comb begin
        hi_inc       = hi_cnt_q + CNT_ONE;
        lo_inc       = lo_cnt_q + CNT_ONE;
        period_sum   = {1'b0, hi_lat_q} + {1'b0, lo_cnt_q};
        period_match = (hi_lat_q == HIGH_EXP) && (period_sum == PERIOD_EXP);
    end

    always_comb begin
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        hi_lat_d      = hi_lat_q;
        meas_high_d   = meas_high_q;
        meas_period_d = meas_period_q;
        meas_valid_d  = 1'b0;
        duty_ok_d     = duty_ok_q;
        stuck_d       = stuck_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            IDLE: begin
                // A fall seen here belongs to a period we never saw start.
                if (rise) begin
                    state_d  = HIGH;
                    hi_cnt_d = CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d  = LOW;
                    lo_cnt_d = CNT_ONE;
                    hi_lat_d = hi_cnt_q;
                end else if (hi_inc == CNT_MAX) begin
                    state_d   = STUCK;
                    stuck_d   = 1'b1;
                    duty_ok_d = 1'b0;
                    hi_cnt_d  = '0;
                    lo_cnt_d  = '0;
                end else begin
                    hi_cnt_d = hi_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    meas_high_d   = hi_lat_q;
                    meas_period_d = period_sum;
                    meas_valid_d  = 1'b1;
                    duty_ok_d     = period_match;
                    if (!period_match) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    state_d  = HIGH;
                    hi_cnt_d = CNT_ONE;
                    lo_cnt_d = '0;
                end else if (lo_inc == CNT_MAX) begin
                    state_d   = STUCK;
                    stuck_d   = 1'b1;
                    duty_ok_d = 1'b0;
                    hi_cnt_d  = '0;
                    lo_cnt_d  = '0;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d  = HIGH;
                    stuck_d  = 1'b0;
                    hi_cnt_d = CNT_ONE;
                end else if (fall) begin
                    state_d = IDLE;
                    stuck_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            hi_lat_q      <= '0;
            meas_high_q   <= '0;
            meas_period_q <= '0;
            meas_valid_q  <= 1'b0;
            duty_ok_q     <= 1'b0;
            stuck_q       <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            hi_lat_q      <= hi_lat_d;
            meas_high_q   <= meas_high_d;
            meas_period_q <= meas_period_d;
            meas_valid_q  <= meas_valid_d;
            duty_ok_q     <= duty_ok_d;
            stuck_q       <= stuck_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign meas_high   = meas_high_q;
    assign meas_period = meas_period_q;
    assign meas_valid  = meas_valid_q;
    assign duty_ok     = duty_ok_q;
    assign stuck       = stuck_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_duty_monitor.sv
// Directed bench for duty_monitor; SL adapts expected latency when DUTY_MON_SYNC_EN is defined.
module tb_duty_monitor;

`ifdef DUTY_MON_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] meas_high;
    logic [8:0] meas_period;
    logic       meas_valid;
    logic       duty_ok;
    logic       stuck;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int mv_count = 0;
    int mv_cyc = 0;
    int last_gap = 0;
    int base = 0;
    int rise_cyc = 0;

    duty_monitor #(.PERIOD(10), .HIGH_CYCLES(6), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .sig_in      (sig_in),
        .meas_high   (meas_high),
        .meas_period (meas_period),
        .meas_valid  (meas_valid),
        .duty_ok     (duty_ok),
        .stuck       (stuck),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            last_gap = cyc_n - mv_cyc;
            mv_cyc   = cyc_n;
            mv_count = mv_count + 1;
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            sig_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 2);
    endtask

    initial begin
        // Power-on reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_meas_high", 32'(meas_high), 0);
        chk("rst_meas_period", 32'(meas_period), 0);
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_duty_ok", 32'(duty_ok), 0);
        chk("rst_stuck", 32'(stuck), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;
        drive(1'b0, 2);

        // 6 high / 4 low: five complete matching periods
        base = mv_count;
        for (int p = 0; p < 6; p++) begin
            drive(1'b1, 1);
            rise_cyc = cyc_n;
            drive(1'b1, 5);
            drive(1'b0, 4);
        end
        chk("a_valid_count", 32'(mv_count - base), 5);
        chk("a_meas_high", 32'(meas_high), 6);
        chk("a_meas_period", 32'(meas_period), 10);
        chk("a_duty_ok", 32'(duty_ok), 1);
        chk("a_err_cnt", 32'(err_cnt), 0);
        chk("a_valid_pulse_low", 32'(meas_valid), 0);
        chk("a_valid_gap", 32'(last_gap), 10);
        chk("a_latency", 32'(mv_cyc), 32'(rise_cyc + SL));

        // 5 high / 5 low: right period, wrong high time
        do_reset();
        base = mv_count;
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        chk("b_valid_count", 32'(mv_count - base), 3);
        chk("b_meas_high", 32'(meas_high), 5);
        chk("b_meas_period", 32'(meas_period), 10);
        chk("b_duty_ok", 32'(duty_ok), 0);
        chk("b_err_cnt", 32'(err_cnt), 3);
        chk("b_valid_gap", 32'(last_gap), 10);
        drive(1'b1, 5);
        chk("b_err_cnt_next", 32'(err_cnt), 4);

        // High phase held until stuck, then fall back to IDLE
        do_reset();
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 254 + SL);
        base = mv_count;
        chk("c_duty_ok_before", 32'(duty_ok), 1);
        chk("c_stuck_254", 32'(stuck), 0);
        drive(1'b1, 1);
        chk("c_stuck_255", 32'(stuck), 1);
        chk("c_duty_ok_stuck", 32'(duty_ok), 0);
        drive(1'b1, 45);
        chk("c_stuck_hold", 32'(stuck), 1);
        drive(1'b0, 1 + SL);
        chk("c_stuck_clear", 32'(stuck), 0);
        chk("c_no_valid", 32'(mv_count - base), 0);
        drive(1'b0, 3);
        drive(1'b1, 6);
        drive(1'b0, 4);
        chk("c_idle_first_rise", 32'(mv_count - base), 0);
        drive(1'b1, 6);
        drive(1'b0, 4);
        chk("c_resume_count", 32'(mv_count - base), 1);
        chk("c_resume_high", 32'(meas_high), 6);
        chk("c_resume_ok", 32'(duty_ok), 1);

        // Low phase held until stuck, then a rise restarts measuring
        do_reset();
        drive(1'b1, 6);
        drive(1'b0, 300);
        chk("d_stuck_low", 32'(stuck), 1);
        base = mv_count;
        drive(1'b1, 6);
        chk("d_stuck_rise_clear", 32'(stuck), 0);
        drive(1'b0, 4);
        drive(1'b1, 6);
        chk("d_valid_count", 32'(mv_count - base), 1);
        chk("d_meas_high", 32'(meas_high), 6);
        chk("d_meas_period", 32'(meas_period), 10);

        // Asynchronous reset in the third cycle of a high phase
        do_reset();
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 2);
        chk("e_pre_meas_high", 32'(meas_high), 6);
        sig_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_async_meas_high", 32'(meas_high), 0);
        chk("e_async_meas_period", 32'(meas_period), 0);
        chk("e_async_meas_valid", 32'(meas_valid), 0);
        chk("e_async_duty_ok", 32'(duty_ok), 0);
        chk("e_async_stuck", 32'(stuck), 0);
        chk("e_async_err_cnt", 32'(err_cnt), 0);
        @(posedge clk);
        #1;
        drive(1'b0, 2);
        rst_n = 1'b1;
        drive(1'b0, 3);
        base = mv_count;
        drive(1'b1, 6);
        drive(1'b0, 4);
        chk("e_no_early_valid", 32'(mv_count - base), 0);
        drive(1'b1, 1);
        rise_cyc = cyc_n;
        drive(1'b1, 5);
        chk("e_valid_count", 32'(mv_count - base), 1);
        chk("e_latency", 32'(mv_cyc), 32'(rise_cyc + SL));
        chk("e_meas_high", 32'(meas_high), 6);
        chk("e_meas_period", 32'(meas_period), 10);
        chk("e_duty_ok", 32'(duty_ok), 1);

        // 1/1 toggle: 300 mismatched periods saturate the error count
        do_reset();
        base = mv_count;
        for (int i = 0; i < 301; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 3);
        chk("f_valid_count", 32'(mv_count - base), 300);
        chk("f_meas_high", 32'(meas_high), 1);
        chk("f_meas_period", 32'(meas_period), 2);
        chk("f_duty_ok", 32'(duty_ok), 0);
        chk("f_err_sat", 32'(err_cnt), 255);
        chk("f_valid_gap", 32'(last_gap), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/duty_monitor.md
DUTY_MONITOR -- requirements
Module: duty_monitor

Interface
REQ-001 Parameter PERIOD, default 10: expected waveform period in clk cycles.
REQ-002 Parameter HIGH_CYCLES, default 6: expected high time in clk cycles.
REQ-003 Parameter CNT_W, default 8: width of the high and low phase counters.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sig_in  input  1  monitored divided-clock waveform from the upstream clock divider, same clk domain.
REQ-007 meas_high  output  CNT_W  high-phase length of the last complete period.
REQ-008 meas_period  output  CNT_W+1  length of the last complete period, high plus low.
REQ-009 meas_valid  output  1  one-cycle pulse when meas_high and meas_period update.
REQ-010 duty_ok  output  1  last complete period matched both PERIOD and HIGH_CYCLES.
REQ-011 stuck  output  1  sig_in has had no edge for 2**CNT_W-1 cycles.
REQ-012 err_cnt  output  8  saturating count of mismatched periods.

Function
REQ-013 Registered previous sample sig_q; rise = sig_in & ~sig_q; fall = ~sig_in & sig_q.
REQ-014 FSM states SHALL be IDLE, HIGH, LOW and STUCK.
REQ-015 IDLE: on rise, go to HIGH with hi_cnt=1; the first fall SHALL be ignored; no measurement is made before the first rise.
REQ-016 HIGH: hi_cnt increments each cycle sig_in=1; on fall, go to LOW with lo_cnt=1 and latch hi_cnt.
REQ-017 LOW: lo_cnt increments each cycle sig_in=0; on rise, complete a period, go to HIGH with hi_cnt=1.
REQ-018 On period completion, the next cycle SHALL drive meas_high=latched hi, meas_period=hi+lo (CNT_W+1 bits, no overflow), meas_valid=1 for exactly one cycle.
REQ-019 duty_ok SHALL update with meas_valid to (hi==HIGH_CYCLES && hi+lo==PERIOD) and hold until the next measurement.
REQ-020 On a mismatch, err_cnt SHALL increment alongside meas_valid and saturate at 255.
REQ-021 If hi_cnt or lo_cnt reaches 2**CNT_W-1, go to STUCK, stuck=1, duty_ok=0; the partial period SHALL be discarded.
REQ-022 STUCK: on rise, clear stuck and go to HIGH with hi_cnt=1; on fall, clear stuck and go to IDLE.
REQ-023 A one-cycle glitch SHALL count as a legal 1-cycle phase; no filtering.
REQ-024 Measurement latency from the rise closing a period to meas_valid SHALL be 1 clk cycle (+2 with DUTY_MON_SYNC_EN).

Reset
REQ-025 reset low SHALL asynchronously force state=IDLE, sig_q=0, counters=0, meas_high=0, meas_period=0, meas_valid=0, duty_ok=0, stuck=0, err_cnt=0.
REQ-026 Reset mid-period SHALL discard the partial period; measurement resumes at the next rise after release.

Configuration
REQ-027 With DUTY_MON_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer (reset to 0) before edge detection, for asynchronous sources.
REQ-028 Without DUTY_MON_SYNC_EN, sig_in SHALL feed edge detection directly, with no added latency.

Structure
REQ-029 Package duty_mon_pkg SHALL hold the state enum (IDLE, HIGH, LOW, STUCK) and the ERR_MAX=255 constant.
REQ-030 Sub-module duty_edge_det SHALL contain the optional synchronizer, the sig_q register and the rise/fall outputs.

Verification
REQ-031 Drive 6-high/4-low, 5 periods -> meas_valid every 10 cycles, meas_high=6, meas_period=10, duty_ok=1, err_cnt=0.
REQ-032 Drive 5-high/5-low -> meas_high=5, meas_period=10, duty_ok=0, err_cnt increments by 1 per period.
REQ-033 Hold sig_in=1 for 300 cycles with CNT_W=8 -> stuck=1 after 255 high cycles; next fall clears stuck and returns to IDLE; no meas_valid.
REQ-034 Assert reset at cycle 3 of a high phase -> all outputs 0 asynchronously; the first meas_valid follows one full period after the next rise.
REQ-035 1-high/1-low toggle -> meas_high=1, meas_period=2 each valid; 300 mismatched periods -> err_cnt holds at 255.
REQ-036 With DUTY_MON_SYNC_EN, 6/4 stimulus -> same values as REQ-031, meas_valid delayed 2 cycles.
